// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial engines.
package spart_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_t;

endpackage

// File: rtl/spart_baud_cnt.sv
// Loadable bit-period down-counter; tick_o is high while the count sits at zero.
module spart_baud_cnt #(
  parameter int unsigned Width = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spart_rx_engine.sv
// SPART UART receiver: runtime divisor, configurable frame format, error status and
// a one-entry valid/ready holding register.
module spart_rx_engine
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter parity_t     PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned      CntW     = 4;
  localparam logic [CntW-1:0]  LastData = CntW'(DATA_BITS - 1);
  localparam logic [CntW-1:0]  LastStop = CntW'(STOP_BITS - 1);
  localparam logic [DIV_W-1:0] DivMin   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DivOne   = DIV_W'(1);

  logic                 sync1_q, rxs_q, rxs_prev_q, fall;
  rx_state_t            st_q, st_d;
  logic [DIV_W-1:0]     div_q, div_d, eff_div, cnt_val;
  logic                 cnt_load, tick;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d, par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 brk_q, brk_d, ovr_q, ovr_d;
  logic                 exp_par, frame_brk, commit_ok;

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall      = rxs_prev_q & ~rxs_q;
  assign eff_div   = (baud_div < DivMin) ? DivMin : baud_div;
  assign exp_par   = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;
  assign frame_brk = (shift_q == '0) & ~par_bit_q & frm_err_q;
  assign commit_ok = ~valid_q | rx_ready;

  spart_baud_cnt #(
    .Width(DIV_W)
  ) u_baud_cnt (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .tick_o    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:   if (fall) st_d = StStart;
      StStart:  if (tick) st_d = rxs_q ? StIdle : StData;
      StData: begin
        if (tick && bit_cnt_q == LastData) st_d = (PARITY == PAR_NONE) ? StStop : StParity;
      end
      StParity: if (tick) st_d = StStop;
      StStop:   if (tick && bit_cnt_q == LastStop) st_d = StDone;
      StDone:   st_d = StIdle;
      default:  st_d = StIdle;
    endcase
  end

  // Sample points: half a bit after the start edge, then every div_q clocks.
  always_comb begin
    div_d     = div_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    par_bit_d = par_bit_q;
    cnt_load  = 1'b0;
    cnt_val   = div_q - DivOne;
    unique case (st_q)
      StIdle: begin
        if (fall) begin
          div_d     = eff_div;
          cnt_load  = 1'b1;
          cnt_val   = (eff_div >> 1) - DivOne;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          par_bit_d = 1'b0;
        end
      end
      StStart: cnt_load = tick;
      StData: begin
        if (tick) begin
          cnt_load  = 1'b1;
          shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = (bit_cnt_q == LastData) ? '0 : bit_cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (tick) begin
          cnt_load  = 1'b1;
          par_bit_d = rxs_q;
          par_err_d = (rxs_q != exp_par);
        end
      end
      StStop: begin
        if (tick) begin
          cnt_load  = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (!rxs_q) frm_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    ovr_d   = 1'b0;
    if (st_q == StDone) begin
      if (commit_ok) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = par_err_q;
        ferr_d  = frm_err_q;
        brk_d   = frame_brk;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    busy       = (st_q != StIdle);
    rx_data    = data_q;
    rx_valid   = valid_q;
    parity_err = perr_q;
    frame_err  = ferr_q;
    break_det  = brk_q;
    overrun    = ovr_q;
  end

endmodule

// File: tb/tb_spart_rx_engine.sv
// Self-checking bench for spart_rx_engine: 8N1 instance plus an even-parity instance.
module tb_spart_rx_engine;
  import spart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1, rx_ready = 1'b1;
  logic [12:0] baud_div = 13'd434;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, break_det, overrun, busy;

  logic        rx_p = 1'b1, rx_ready_p = 1'b1;
  logic [12:0] baud_div_p = 13'd40;
  logic [7:0]  rx_data_p;
  logic        rx_valid_p, parity_err_p, frame_err_p, break_det_p, overrun_p, busy_p;

  int n_cmp = 0, n_bad = 0;
  logic [10:0] got_mem [256];
  logic [10:0] got_p_mem [256];
  int got_n = 0, got_p_n = 0, rd = 0, rd_p = 0;
  int ovr_cnt = 0, ovr_p_cnt = 0;

  always #5 clk = ~clk;

  spart_rx_engine u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .baud_div(baud_div),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun), .busy(busy)
  );

  spart_rx_engine #(.PARITY(PAR_EVEN)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .baud_div(baud_div_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
    .parity_err(parity_err_p), .frame_err(frame_err_p), .break_det(break_det_p),
    .overrun(overrun_p), .busy(busy_p)
  );

  // Record every accepted transfer as {break, frame, parity, data}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        got_mem[got_n[7:0]] <= {break_det, frame_err, parity_err, rx_data};
        got_n <= got_n + 1;
      end
      if (rx_valid_p && rx_ready_p) begin
        got_p_mem[got_p_n[7:0]] <= {break_det_p, frame_err_p, parity_err_p, rx_data_p};
        got_p_n <= got_p_n + 1;
      end
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (overrun_p) ovr_p_cnt <= ovr_p_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input bit par_line, input logic [7:0] d, input bit has_par,
                             input bit par, input bit stop, input int div, input int lim);
    logic [10:0] bits;
    int n, eff;
    eff = (div < 2) ? 2 : div;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (has_par) begin
      bits[9] = par;
      bits[10] = stop;
      n = 11;
    end else begin
      bits[9] = stop;
      n = 10;
    end
    if (lim < n) n = lim;
    for (int i = 0; i < n; i++) begin
      if (par_line) rx_p = bits[i];
      else rx = bits[i];
      step(eff);
    end
  endtask

  task automatic idle_line(input bit par_line, input int div);
    if (par_line) rx_p = 1'b1;
    else rx = 1'b1;
    step(2 * ((div < 2) ? 2 : div));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    n_cmp++;
    if ({rx_valid, parity_err, frame_err, break_det, overrun, busy} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {rx_valid, parity_err, frame_err, break_det, overrun, busy});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00", rx_data);
    end
    rst_n = 1'b1;
    step(4);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_false_start: busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int o0;
    o0 = ovr_cnt;
    baud_div = 13'd434;
    drive_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 434, 99);
    step(8);
    n_cmp++;
    if (got_n - rd !== 1) begin
      n_bad++;
      $display("FAIL basic_beats: got %0d want 1", got_n - rd);
    end
    if (got_n > rd) begin
      n_cmp++;
      if (got_mem[rd[7:0]] !== {3'b000, 8'hA5}) begin
        n_bad++;
        $display("FAIL basic_frame: got %h want %h", got_mem[rd[7:0]], {3'b000, 8'hA5});
      end
    end
    n_cmp++;
    if (rx_valid !== 1'b0 || ovr_cnt != o0) begin
      n_bad++;
      $display("FAIL basic_after: valid %b ovr %0d want 0 0", rx_valid, ovr_cnt - o0);
    end
    rd = got_n;
  endtask

  task automatic test_min_div();
    logic [7:0] d;
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      baud_div = 13'(k);
      idle_line(1'b0, 2);
      drive_frame(1'b0, d, 1'b0, 1'b0, 1'b1, 2, 99);
      step(8);
      n_cmp++;
      if (got_n - rd !== 1 || got_mem[rd[7:0]] !== {3'b000, d}) begin
        n_bad++;
        $display("FAIL min_div%0d: beats %0d frame %h want 1 %h", k, got_n - rd,
                 got_mem[rd[7:0]], {3'b000, d});
      end
      rd = got_n;
    end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic [10:0] exp;
    bit          stop;
    int          div;
    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom);
      if (k == 3) d = 8'h00;
      stop = ($urandom_range(0, 3) != 0);
      div  = $urandom_range(3, 40);
      exp  = {(d == 8'h00) && !stop, !stop, 1'b0, d};
      baud_div = 13'(div);
      idle_line(1'b0, div);
      drive_frame(1'b0, d, 1'b0, 1'b0, stop, div, 99);
      step(8);
      n_cmp++;
      if (got_n - rd !== 1 || got_mem[rd[7:0]] !== exp) begin
        n_bad++;
        $display("FAIL random%0d div %0d: beats %0d frame %h want 1 %h", k, div, got_n - rd,
                 got_mem[rd[7:0]], exp);
      end
      rd = got_n;
    end
    idle_line(1'b0, 40);
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    baud_div = 13'd52;
    idle_line(1'b0, 52);
    drive_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 52, 99);
    step(8);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      n_bad++;
      $display("FAIL overrun_first_held: valid %b data %h want 1 3c", rx_valid, rx_data);
    end
    idle_line(1'b0, 52);
    drive_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 52, 99);
    step(8);
    n_cmp++;
    if (ovr_cnt - o0 !== 1) begin
      n_bad++;
      $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - o0);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      n_bad++;
      $display("FAIL overrun_keep_old: valid %b data %h want 1 3c", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
    n_cmp++;
    if (got_n - rd !== 1 || got_mem[rd[7:0]] !== {3'b000, 8'h3C} || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_drain: beats %0d frame %h valid %b want 1 03c 0", got_n - rd,
               got_mem[rd[7:0]], rx_valid);
    end
    rd = got_n;
    rx_ready = 1'b1;
  endtask

  task automatic test_parity();
    logic [7:0]  d;
    logic [10:0] exp;
    bit          par;
    for (int k = 0; k < 6; k++) begin
      d   = (k < 2) ? 8'h07 : 8'($urandom);
      par = (k < 2) ? k[0] : 1'($urandom);
      exp = {(d == 8'h00) && 1'b0, 1'b0, par != ^d, d};
      idle_line(1'b1, 40);
      drive_frame(1'b1, d, 1'b1, par, 1'b1, 40, 99);
      step(8);
      n_cmp++;
      if (got_p_n - rd_p !== 1 || got_p_mem[rd_p[7:0]] !== exp) begin
        n_bad++;
        $display("FAIL parity%0d par %b: beats %0d frame %h want 1 %h", k, par,
                 got_p_n - rd_p, got_p_mem[rd_p[7:0]], exp);
      end
      rd_p = got_p_n;
    end
    n_cmp++;
    if (ovr_p_cnt !== 0 || busy_p !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_idle: ovr %0d busy %b want 0 0", ovr_p_cnt, busy_p);
    end
  endtask

  task automatic test_break();
    baud_div = 13'd40;
    idle_line(1'b0, 40);
    drive_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 40, 99);
    step(8);
    n_cmp++;
    if (got_n - rd !== 1 || got_mem[rd[7:0]] !== {3'b110, 8'h00}) begin
      n_bad++;
      $display("FAIL break_frame: beats %0d frame %h want 1 600", got_n - rd, got_mem[rd[7:0]]);
    end
    rd = got_n;
    step(200);
    n_cmp++;
    if (busy !== 1'b0 || got_n !== rd) begin
      n_bad++;
      $display("FAIL break_no_retrigger: busy %b beats %0d want 0 0", busy, got_n - rd);
    end
    idle_line(1'b0, 40);
    drive_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 40, 99);
    step(8);
    n_cmp++;
    if (got_n - rd !== 1 || got_mem[rd[7:0]] !== {3'b000, 8'h55}) begin
      n_bad++;
      $display("FAIL break_recover: beats %0d frame %h want 1 055", got_n - rd,
               got_mem[rd[7:0]]);
    end
    rd = got_n;
  endtask

  task automatic test_glitch();
    int c;
    baud_div = 13'd434;
    idle_line(1'b0, 434);
    rx = 1'b0;
    step(100);
    rx = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_start_seen: busy got %b want 1", busy);
    end
    c = 100;
    while (busy && c < 224) begin
      step(1);
      c++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy_timeout: busy %b after %0d clks want 0", busy, c);
    end
    step(4);
    n_cmp++;
    if (rx_valid !== 1'b0 || got_n !== rd) begin
      n_bad++;
      $display("FAIL glitch_no_output: valid %b beats %0d want 0 0", rx_valid, got_n - rd);
    end
  endtask

  task automatic test_reset_mid();
    baud_div = 13'd100;
    idle_line(1'b0, 100);
    drive_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 100, 5);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_valid, parity_err, frame_err, break_det, overrun, busy} !== 6'b0
        || rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_outputs: flags %b data %h want 000000 00",
               {rx_valid, parity_err, frame_err, break_det, overrun, busy}, rx_data);
    end
    step(2);
    rx = 1'b1;
    rst_n = 1'b1;
    step(4);
    rd = got_n;
    idle_line(1'b0, 100);
    drive_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 100, 99);
    step(8);
    n_cmp++;
    if (got_n - rd !== 1 || got_mem[rd[7:0]] !== {3'b000, 8'h12}) begin
      n_bad++;
      $display("FAIL rstmid_next: beats %0d frame %h want 1 012", got_n - rd, got_mem[rd[7:0]]);
    end
    rd = got_n;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_div();
    test_random();
    test_overrun();
    test_parity();
    test_break();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
